// File: rtl/apb_cmd_scheduler.sv
// Command scheduler: parses header/data packets from the command FIFO, dispatches them
// to one of four APB channel engines, and round-robin merges read responses to the return FIFO.
module apb_cmd_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         empty,
  input  logic [31:0]  rdata,
  output logic         rdata_en,
  output logic [3:0]   cmd_vld,
  input  logic [3:0]   cmd_rdy,
  output logic         cmd_write,
  output logic [23:0]  cmd_addr,
  output logic [31:0]  cmd_wdata,
  input  logic [3:0]   rsp_vld,
  input  logic [127:0] rsp_data,
  output logic [3:0]   rsp_ack,
  input  logic         full,
  output logic         wdata_vld,
  output logic [31:0]  wdata,
  output logic         err_pkt,
  output logic         err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DPOP, S_DAT, S_ISSUE} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  ch_q;
  logic [23:0] pend_addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic        cmd_write_q;
  logic [23:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic        err_pkt_q;
  logic        err_timeout_q;

  logic [3:0]  ch_onehot;
  logic        ch_ready;
  state_e      hdr_next;

  // Header decision rules, shared by HDR and by DAT when a header shows up in place of data.
  always_comb begin
    hdr_next = S_IDLE;
    if (!rdata[0] && rdata[2]) begin
      hdr_next = rdata[1] ? S_DPOP : S_ISSUE;
    end
  end

  assign ch_onehot = 4'b0001 << ch_q;
  assign ch_ready  = |(cmd_rdy & ch_onehot);
  assign rdata_en  = !empty && ((state_q == S_IDLE) || (state_q == S_DPOP));
  assign cmd_vld   = (state_q == S_ISSUE) ? (cmd_rdy & ch_onehot) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ch_q          <= 2'd0;
      pend_addr_q   <= '0;
      cnt_q         <= '0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      err_pkt_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_pkt_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: if (!empty) state_q <= S_HDR;
        S_HDR, S_DAT: begin
          if ((state_q == S_DAT) && rdata[0]) begin
            cmd_write_q <= 1'b1;
            cmd_addr_q  <= pend_addr_q;
            cmd_wdata_q <= {1'b0, rdata[31:1]};
            state_q     <= S_ISSUE;
          end else begin
            // In DAT this branch means the data word is missing: flag it and treat the word as a header.
            err_pkt_q   <= rdata[0] || (state_q == S_DAT);
            ch_q        <= rdata[4:3];
            pend_addr_q <= rdata[31:8];
            if (hdr_next == S_ISSUE) begin
              cmd_write_q <= 1'b0;
              cmd_addr_q  <= rdata[31:8];
            end
            state_q <= hdr_next;
          end
        end
        S_DPOP: if (!empty) state_q <= S_DAT;
        S_ISSUE: begin
          if (ch_ready) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            err_timeout_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_wdata   = cmd_wdata_q;
  assign err_pkt     = err_pkt_q;
  assign err_timeout = err_timeout_q;

  // Response arbiter
  logic [1:0]  ptr_q;
  logic [3:0]  ack_prev_q;
  logic        wdata_vld_q;
  logic [31:0] wdata_q;
  logic [3:0]  req;
  logic        grant_any;
  logic [1:0]  grant_idx;
  logic [1:0]  scan_idx;
  logic [31:0] rsp_word [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_rsp_word
    assign rsp_word[gi] = rsp_data[32*gi +: 32];
  end

  // A channel just acked still shows rsp_vld for one cycle; mask it so it is not granted twice.
  assign req = full ? 4'b0000 : (rsp_vld & ~ack_prev_q);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!grant_any && req[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign rsp_ack = grant_any ? (4'b0001 << grant_idx) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      ack_prev_q  <= 4'b0000;
      wdata_vld_q <= 1'b0;
      wdata_q     <= '0;
    end else begin
      ack_prev_q  <= rsp_ack;
      wdata_vld_q <= grant_any;
      if (grant_any) begin
        ptr_q   <= grant_idx + 2'd1;
        wdata_q <= rsp_word[grant_idx];
      end
    end
  end

  assign wdata_vld = wdata_vld_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_apb_cmd_scheduler.sv
// Directed testbench for apb_cmd_scheduler: command FIFO model, channel ready/response
// stimulus and cycle-accurate checks of dispatch, errors and response arbitration.
module tb_apb_cmd_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         empty;
  logic [31:0]  rdata = '0;
  logic         rdata_en;
  logic [3:0]   cmd_vld;
  logic [3:0]   cmd_rdy = 4'b0000;
  logic         cmd_write;
  logic [23:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic [3:0]   rsp_vld = 4'b0000;
  logic [127:0] rsp_data = '0;
  logic [3:0]   rsp_ack;
  logic         full = 1'b0;
  logic         wdata_vld;
  logic [31:0]  wdata;
  logic         err_pkt;
  logic         err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_cmd_scheduler #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rdata(rdata), .rdata_en(rdata_en),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .full(full), .wdata_vld(wdata_vld), .wdata(wdata), .err_pkt(err_pkt),
    .err_timeout(err_timeout)
  );

  // Command FIFO model with one-cycle read latency
  logic [31:0] fifo_mem [64];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  int  pop_cnt = 0;
  bit  pop_while_empty = 1'b0;

  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rdata_en) begin
      if (empty) pop_while_empty <= 1'b1;
      rdata   <= fifo_mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rdata_en, cmd_vld, cmd_write, rsp_ack, wdata_vld, err_pkt, err_timeout} !== 13'd0) begin
        errors++;
        $display("FAIL reset_strobes: got en=%b vld=%b wr=%b ack=%b wv=%b ep=%b et=%b, want all 0",
                 rdata_en, cmd_vld, cmd_write, rsp_ack, wdata_vld, err_pkt, err_timeout);
      end
      checks++;
      if ({cmd_addr, cmd_wdata, wdata} !== 88'd0) begin
        errors++;
        $display("FAIL reset_data: got addr=%h wdata=%h rwdata=%h, want 0", cmd_addr, cmd_wdata, wdata);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_write();
    int p_cyc = -1, v_cyc = -1, vld_n = 0, pops0;
    logic [3:0] vld_seen = '0;
    logic w = 1'b0;
    logic [23:0] a = '0;
    logic [31:0] d = '0;
    bit errp = 1'b0;
    pops0 = pop_cnt;
    cmd_rdy = 4'hF;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin push(32'h0000_0406); push(32'h0000_0011); end
      #1;
      if (rdata_en && p_cyc < 0) p_cyc = c;
      if (cmd_vld != 4'b0000) begin
        vld_n++; v_cyc = c; vld_seen = cmd_vld; w = cmd_write; a = cmd_addr; d = cmd_wdata;
      end
      if (err_pkt) errp = 1'b1;
    end
    checks++; if (vld_seen !== 4'b0001) begin errors++; $display("FAIL wr_vld: got %b want 0001", vld_seen); end
    checks++; if (vld_n != 1) begin errors++; $display("FAIL wr_vld_count: got %0d want 1", vld_n); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL wr_write: got %b want 1", w); end
    checks++; if (a !== 24'h000004) begin errors++; $display("FAIL wr_addr: got %h want 000004", a); end
    checks++; if (d !== 32'h0000_0008) begin errors++; $display("FAIL wr_wdata: got %h want 00000008", d); end
    checks++; if (pop_cnt - pops0 != 2) begin errors++; $display("FAIL wr_pops: got %0d want 2", pop_cnt - pops0); end
    checks++; if (v_cyc - p_cyc != 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", v_cyc - p_cyc); end
    checks++; if (errp) begin errors++; $display("FAIL wr_err_pkt: got 1 want 0"); end
    $display("test_write: vld=%b addr=%h wdata=%h latency=%0d", vld_seen, a, d, v_cyc - p_cyc);
  endtask

  task automatic test_nop();
    int pops0, vld_n = 0;
    bit errp = 1'b0;
    pops0 = pop_cnt;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) push(32'h0000_1212);  // ctrl 0x12: bit2 clear, so no command
      #1;
      if (cmd_vld != 4'b0000) vld_n++;
      if (err_pkt) errp = 1'b1;
    end
    checks++; if (vld_n != 0 || errp) begin errors++; $display("FAIL nop_ignored: got vld_n=%0d err=%b want 0/0", vld_n, errp); end
    checks++; if (pop_cnt - pops0 != 1) begin errors++; $display("FAIL nop_pops: got %0d want 1", pop_cnt - pops0); end
    checks++; if (cmd_addr !== 24'h000004) begin errors++; $display("FAIL nop_addr_hold: got %h want 000004", cmd_addr); end
    $display("test_nop: pops=%0d", pop_cnt - pops0);
  endtask

  task automatic test_read_backpressure();
    bit early = 1'b0, to_seen = 1'b0;
    cmd_rdy = 4'b1011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) push(32'h0000_1214);  // read, channel 2, addr 0x12
      if (c == 7) cmd_rdy = 4'hF;
      #1;
      if (err_timeout) to_seen = 1'b1;
      if (c >= 2 && c <= 6 && cmd_vld != 4'b0000) early = 1'b1;
      if (c == 7) begin
        checks++; if (cmd_vld !== 4'b0100) begin errors++; $display("FAIL rd_vld: got %b want 0100", cmd_vld); end
        checks++; if (cmd_addr !== 24'h000012 || cmd_write !== 1'b0) begin
          errors++; $display("FAIL rd_cmd: got addr=%h write=%b want 000012/0", cmd_addr, cmd_write);
        end
      end
      if (c == 8) begin
        checks++; if (cmd_vld !== 4'b0000) begin errors++; $display("FAIL rd_vld_pulse: got %b want 0000", cmd_vld); end
      end
    end
    checks++; if (early) begin errors++; $display("FAIL rd_backpressure: got vld while rdy low, want none"); end
    checks++; if (to_seen) begin errors++; $display("FAIL rd_no_timeout: got err_timeout, want none"); end
    $display("test_read_backpressure: addr=%h", cmd_addr);
  endtask

  task automatic test_timeout();
    int t_cyc = -1, t_n = 0, v_cyc = -1, vld_n = 0;
    logic [3:0] vld_seen = '0;
    cmd_rdy = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) push(32'h0000_551C);  // read, channel 3, addr 0x55
      if (c == 11) begin cmd_rdy = 4'hF; push(32'h0000_661C); end
      #1;
      if (err_timeout) begin t_n++; if (t_cyc < 0) t_cyc = c; end
      if (cmd_vld != 4'b0000) begin vld_n++; v_cyc = c; vld_seen = cmd_vld; end
    end
    checks++; if (t_cyc != 10 || t_n != 1) begin errors++; $display("FAIL to_pulse: got cycle=%0d count=%0d want 10/1", t_cyc, t_n); end
    checks++; if (vld_n != 1 || v_cyc != 13) begin errors++; $display("FAIL to_vld: got count=%0d cycle=%0d want 1/13", vld_n, v_cyc); end
    checks++; if (vld_seen !== 4'b1000 || cmd_addr !== 24'h000066) begin
      errors++; $display("FAIL to_next_pkt: got vld=%b addr=%h want 1000/000066", vld_seen, cmd_addr);
    end
    $display("test_timeout: err_timeout at cycle %0d, next dispatch at cycle %0d", t_cyc, v_cyc);
  endtask

  task automatic test_malformed();
    int e_first = -1, e_last = -1, e_n = 0, v_cyc = -1, vld_n = 0, pops0;
    logic [3:0] vld_seen = '0;
    logic w = 1'b0;
    logic [23:0] a = '1;
    logic [31:0] d = '0;
    pops0 = pop_cnt;
    cmd_rdy = 4'hF;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) push(32'h0000_0011);
      if (c == 4) begin push(32'h0000_0406); push(32'h0000_0006); push(32'h0000_0021); end
      #1;
      if (err_pkt) begin e_n++; if (e_first < 0) e_first = c; e_last = c; end
      if (cmd_vld != 4'b0000) begin
        vld_n++; v_cyc = c; vld_seen = cmd_vld; w = cmd_write; a = cmd_addr; d = cmd_wdata;
      end
    end
    checks++; if (e_n != 2 || e_first != 2 || e_last != 8) begin
      errors++; $display("FAIL bad_err_pkt: got count=%0d first=%0d last=%0d want 2/2/8", e_n, e_first, e_last);
    end
    checks++; if (vld_n != 1 || v_cyc != 10 || vld_seen !== 4'b0001) begin
      errors++; $display("FAIL bad_dispatch: got count=%0d cycle=%0d vld=%b want 1/10/0001", vld_n, v_cyc, vld_seen);
    end
    checks++; if (w !== 1'b1 || a !== 24'h000000 || d !== 32'h0000_0010) begin
      errors++; $display("FAIL bad_cmd: got write=%b addr=%h wdata=%h want 1/000000/00000010", w, a, d);
    end
    checks++; if (pop_cnt - pops0 != 4) begin errors++; $display("FAIL bad_pops: got %0d want 4", pop_cnt - pops0); end
    $display("test_malformed: err_pkt count=%0d dispatch cycle=%0d", e_n, v_cyc);
  endtask

  task automatic test_arbitration();
    logic [3:0]  exp_ack [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic        exp_wv  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_wd  [7] = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0};
    logic [3:0]  ack_last = 4'b0000;
    full = 1'b0;
    rsp_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) rsp_vld = 4'hF;
      rsp_vld = rsp_vld & ~ack_last;
      #1;
      checks++; if (rsp_ack !== exp_ack[c]) begin errors++; $display("FAIL arb_ack[%0d]: got %b want %b", c, rsp_ack, exp_ack[c]); end
      checks++; if (wdata_vld !== exp_wv[c] || (exp_wv[c] && wdata !== exp_wd[c])) begin
        errors++; $display("FAIL arb_push[%0d]: got vld=%b data=%h want %b/%h", c, wdata_vld, wdata, exp_wv[c], exp_wd[c]);
      end
      $display("arb cycle %0d: ack=%b push=%b data=%h", c, rsp_ack, wdata_vld, wdata);
      ack_last = rsp_ack;
    end
  endtask

  task automatic test_full();
    logic [3:0] ack_last = 4'b0000;
    rsp_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin rsp_vld = 4'b0010; full = 1'b1; end
      if (c == 3) full = 1'b0;
      rsp_vld = rsp_vld & ~ack_last;
      #1;
      if (c <= 2) begin
        checks++; if (rsp_ack !== 4'b0000 || wdata_vld !== 1'b0) begin
          errors++; $display("FAIL full_hold[%0d]: got ack=%b push=%b want 0000/0", c, rsp_ack, wdata_vld);
        end
      end else if (c == 3) begin
        checks++; if (rsp_ack !== 4'b0010) begin errors++; $display("FAIL full_release_ack: got %b want 0010", rsp_ack); end
      end else if (c == 4) begin
        checks++; if (wdata_vld !== 1'b1 || wdata !== 32'hB1 || rsp_ack !== 4'b0000) begin
          errors++; $display("FAIL full_push: got vld=%b data=%h ack=%b want 1/000000b1/0000", wdata_vld, wdata, rsp_ack);
        end
      end else begin
        checks++; if (wdata_vld !== 1'b0) begin errors++; $display("FAIL full_single_push: got %b want 0", wdata_vld); end
      end
      $display("full cycle %0d: full=%b ack=%b push=%b data=%h", c, full, rsp_ack, wdata_vld, wdata);
      ack_last = rsp_ack;
    end
  endtask

  task automatic test_back_to_back();
    cmd_rdy = 4'hF;
    rsp_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) push(32'h0000_330C);  // read, channel 1, addr 0x33
      if (c == 2) rsp_vld = 4'b0001;
      if (c == 3) rsp_vld = 4'b0000;
      #1;
      if (c == 2) begin
        checks++; if (cmd_vld !== 4'b0010 || rsp_ack !== 4'b0001) begin
          errors++; $display("FAIL b2b_same_cycle: got vld=%b ack=%b want 0010/0001", cmd_vld, rsp_ack);
        end
      end
      if (c == 3) begin
        checks++; if (wdata_vld !== 1'b1 || wdata !== 32'hC0 || cmd_addr !== 24'h000033) begin
          errors++; $display("FAIL b2b_push: got vld=%b data=%h addr=%h want 1/000000c0/000033", wdata_vld, wdata, cmd_addr);
        end
      end
    end
    $display("test_back_to_back: addr=%h data=%h", cmd_addr, wdata);
  endtask

  initial begin
    test_reset();
    test_write();
    test_nop();
    test_read_backpressure();
    test_timeout();
    test_malformed();
    test_arbitration();
    test_full();
    test_back_to_back();
    checks++;
    if (pop_while_empty) begin errors++; $display("FAIL pop_rule: got rdata_en while empty, want never"); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
